// File: rtl/fifo_ctrl_flags_if.sv
// Request/flag bundle between producer/consumer logic and the FIFO pointer/flag controller.
// master drives the requests and thresholds; slave is the controller side.
interface fifo_ctrl_flags_if #(
  parameter int AW = 4
);
  logic          i_wr;
  logic          i_rd;
  logic          i_clr_err;
  logic [AW:0]   i_af_thresh;
  logic [AW:0]   i_ae_thresh;
  logic          o_wen;
  logic          o_ren;
  logic [AW-1:0] o_waddr;
  logic [AW-1:0] o_raddr;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic          o_overflow;
  logic          o_underflow;

  modport master (
    output i_wr, i_rd, i_clr_err, i_af_thresh, i_ae_thresh,
    input  o_wen, o_ren, o_waddr, o_raddr, o_count, o_full, o_empty,
           o_almost_full, o_almost_empty, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr, i_rd, i_clr_err, i_af_thresh, i_ae_thresh,
    output o_wen, o_ren, o_waddr, o_raddr, o_count, o_full, o_empty,
           o_almost_full, o_almost_empty, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_ctrl_flags.sv
// Pointer/occupancy/flag controller for a single-clock FIFO in front of an external dual-port RAM.
// Occupancy is an explicit AW+1 bit count, so full and empty never alias.
module fifo_ctrl_flags #(
  parameter int AW = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  fifo_ctrl_flags_if.slave bus
);
  localparam int          DEPTH     = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          full, empty, wen, ren;

  always_comb begin
    full  = (count_q == DEPTH_CNT);
    empty = (count_q == '0);
    // A write into a full FIFO is only safe when a read frees a slot in the same cycle.
    ren   = bus.i_rd && !empty;
    wen   = bus.i_wr && (!full || ren);

    waddr_d = wen ? waddr_q + 1'b1 : waddr_q;
    raddr_d = ren ? raddr_q + 1'b1 : raddr_q;

    count_d = count_q;
    if (wen && !ren) begin
      count_d = count_q + 1'b1;
    end else if (ren && !wen) begin
      count_d = count_q - 1'b1;
    end

    // Set has priority over clear so a rejection coinciding with clear is never lost.
    overflow_d  = (bus.i_wr && !wen) || (overflow_q && !bus.i_clr_err);
    underflow_d = (bus.i_rd && !ren) || (underflow_q && !bus.i_clr_err);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      waddr_q     <= '0;
      raddr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.o_wen          = wen;
  assign bus.o_ren          = ren;
  assign bus.o_waddr        = waddr_q;
  assign bus.o_raddr        = raddr_q;
  assign bus.o_count        = count_q;
  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_almost_full  = (count_q >= bus.i_af_thresh);
  assign bus.o_almost_empty = (count_q <= bus.i_ae_thresh);
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl_flags.sv
// Bench for fifo_ctrl_flags at AW=2: vector table fed through an expectation queue,
// plus hand-written liveness and reset-clears-errors sequences.
module tb_fifo_ctrl_flags;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_ctrl_flags_if #(.AW(AW)) bus ();

  fifo_ctrl_flags #(.AW(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // inputs, then outputs expected during that cycle (before the edge that consumes the inputs)
  typedef struct {
    int rst, wr, rd, clr, af, ae;
    int wen, ren, wa, ra, cnt, f, e, afl, ael, ov, un;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   row    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t  e;
    string p;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    p = $sformatf("row%0d", row);
    chk({p, " wen"},   int'(bus.o_wen),          e.wen);
    chk({p, " ren"},   int'(bus.o_ren),          e.ren);
    chk({p, " waddr"}, int'(bus.o_waddr),        e.wa);
    chk({p, " raddr"}, int'(bus.o_raddr),        e.ra);
    chk({p, " count"}, int'(bus.o_count),        e.cnt);
    chk({p, " full"},  int'(bus.o_full),         e.f);
    chk({p, " empty"}, int'(bus.o_empty),        e.e);
    chk({p, " afull"}, int'(bus.o_almost_full),  e.afl);
    chk({p, " aempt"}, int'(bus.o_almost_empty), e.ael);
    chk({p, " ovf"},   int'(bus.o_overflow),     e.ov);
    chk({p, " unf"},   int'(bus.o_underflow),    e.un);
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    rst             = 1'(v.rst);
    bus.i_wr        = 1'(v.wr);
    bus.i_rd        = 1'(v.rd);
    bus.i_clr_err   = 1'(v.clr);
    bus.i_af_thresh = 3'(v.af);
    bus.i_ae_thresh = 3'(v.ae);
    exp_q.push_back(v);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    // rst wr rd clr af ae | wen ren wa ra cnt full empty afl ael ovf unf
    vecs.push_back('{0,0,0,0,3,1, 0,0,0,0,0, 0,1,0,1,0,0});
    vecs.push_back('{0,1,0,0,3,1, 1,0,0,0,0, 0,1,0,1,0,0});
    vecs.push_back('{0,1,0,0,3,1, 1,0,1,0,1, 0,0,0,1,0,0});
    vecs.push_back('{0,1,0,0,3,1, 1,0,2,0,2, 0,0,0,0,0,0});
    vecs.push_back('{0,1,0,0,3,1, 1,0,3,0,3, 0,0,1,0,0,0});
    vecs.push_back('{0,1,0,0,3,1, 0,0,0,0,4, 1,0,1,0,0,0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{0,0,0,0,3,1, 0,0,0,0,4, 1,0,1,0,1,0});
    vecs.push_back('{0,0,0,1,3,1, 0,0,0,0,4, 1,0,1,0,1,0});
    vecs.push_back('{0,0,0,0,3,1, 0,0,0,0,4, 1,0,1,0,0,0});
    vecs.push_back('{0,1,1,0,3,1, 1,1,0,0,4, 1,0,1,0,0,0});
    vecs.push_back('{0,0,0,0,3,1, 0,0,1,1,4, 1,0,1,0,0,0});
    vecs.push_back('{0,0,1,0,3,1, 0,1,1,1,4, 1,0,1,0,0,0});
    vecs.push_back('{0,0,1,0,3,1, 0,1,1,2,3, 0,0,1,0,0,0});
    vecs.push_back('{0,0,1,0,3,1, 0,1,1,3,2, 0,0,0,0,0,0});
    vecs.push_back('{0,0,1,0,3,1, 0,1,1,0,1, 0,0,0,1,0,0});
    vecs.push_back('{0,1,1,0,3,1, 1,0,1,1,0, 0,1,0,1,0,0});
    vecs.push_back('{0,0,1,0,3,1, 0,1,2,1,1, 0,0,0,1,0,1});
    vecs.push_back('{0,0,1,1,3,1, 0,0,2,2,0, 0,1,0,1,0,1});
    vecs.push_back('{0,0,0,0,3,1, 0,0,2,2,0, 0,1,0,1,0,1});
    vecs.push_back('{0,0,0,1,3,1, 0,0,2,2,0, 0,1,0,1,0,1});
    vecs.push_back('{0,0,0,0,3,1, 0,0,2,2,0, 0,1,0,1,0,0});
    vecs.push_back('{0,1,0,0,3,1, 1,0,2,2,0, 0,1,0,1,0,0});
    vecs.push_back('{0,1,0,0,3,1, 1,0,3,2,1, 0,0,0,1,0,0});
    vecs.push_back('{0,0,0,0,3,1, 0,0,0,2,2, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,2,1, 0,0,0,2,2, 0,0,1,0,0,0});
    vecs.push_back('{0,0,0,0,0,4, 0,0,0,2,2, 0,0,1,1,0,0});
    vecs.push_back('{0,1,0,0,3,1, 1,0,0,2,2, 0,0,0,0,0,0});
    vecs.push_back('{1,1,0,0,3,1, 1,0,1,2,3, 0,0,1,0,0,0});
    vecs.push_back('{0,0,0,0,3,1, 0,0,0,0,0, 0,1,0,1,0,0});

    rst             = 1'b1;
    bus.i_wr        = 1'b0;
    bus.i_rd        = 1'b0;
    bus.i_clr_err   = 1'b0;
    bus.i_af_thresh = 3'd3;
    bus.i_ae_thresh = 3'd1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      row = i + 1;
      drive(vecs[i]);
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    // liveness: full exactly DEPTH edges after reset release with writes held
    @(posedge clk);
    #1;
    rst      = 1'b1;
    bus.i_wr = 1'b0;
    bus.i_rd = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.i_wr = 1'b1;
    n = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_full) begin
        n = c;
        break;
      end
    end
    chk("live_full_cycles", n, DEPTH);

    // rejected write sets overflow; reset with a write pending clears everything
    @(posedge clk);
    #1;
    chk("live_ovf_set", int'(bus.o_overflow), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.i_wr = 1'b0;
    chk("rst_ovf",   int'(bus.o_overflow), 0);
    chk("rst_count", int'(bus.o_count),    0);
    chk("rst_waddr", int'(bus.o_waddr),    0);
    chk("rst_empty", int'(bus.o_empty),    1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
